alien_hit_detect: RTL



---
 rtl/alien_hit_detect.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alien_hit_detect.sv
// Alien formation: alive bitmap, marching grid, bullet collision, score and wave clear.
// Optional ALIEN_SPEEDUP_EN shortens the march period as the formation thins out.
module alien_hit_detect #(
  parameter int ROWS     = 5,
  parameter int COLS     = 11,
  parameter int ALIEN_W  = 16,
  parameter int ALIEN_H  = 8,
  parameter int PITCH_X  = 24,
  parameter int PITCH_Y  = 16,
  parameter int START_X  = 64,
  parameter int START_Y  = 48,
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 8,
  parameter int X_MIN    = 16,
  parameter int X_MAX    = 623,
  parameter int MOVE_DIV = 8
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [9:0]           bullet_X,
  input  logic [9:0]           bullet_Y,
  input  logic                 bullet_on_screen,
  output logic                 hit,
  output logic [ROWS*COLS-1:0] alien_alive,
  output logic [9:0]           grid_X,
  output logic [9:0]           grid_Y,
  output logic [15:0]          score,
  output logic                 wave_clear
);

  localparam int N     = ROWS * COLS;
  localparam int SPAN  = (COLS - 1) * PITCH_X + ALIEN_W - 1;
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int PER_W = DIV_W + 1;
  localparam logic [PER_W-1:0] PERIOD_FULL = PER_W'(MOVE_DIV);

  typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_t;

  dir_t             dir, dir_n;
  logic [DIV_W-1:0] divider, div_n;
  logic [PER_W-1:0] period;
  logic             wrap;

  logic [N-1:0]     in_box, cand, kill, alive_n;
  logic             det_found;
  logic [15:0]      det_pts;
  logic             hit_n, wave_n;
  logic [15:0]      score_n;
  logic [16:0]      score_sum;
  logic [9:0]       gx_n, gy_n;

  logic [10:0]      gx11, gy11, bx11, by11;
  logic [10:0]      nx_r, nx_l;
  logic             right_ok, left_ok;

  assign gx11 = {1'b0, grid_X};
  assign gy11 = {1'b0, grid_Y};
  assign bx11 = {1'b0, bullet_X};
  assign by11 = {1'b0, bullet_Y};

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [10:0] x_lo, y_lo;
      assign x_lo = gx11 + 11'(c * PITCH_X);
      assign y_lo = gy11 + 11'(r * PITCH_Y);
      assign in_box[r*COLS+c] = (bx11 >= x_lo) && (bx11 <= x_lo + 11'(ALIEN_W - 1)) &&
                                (by11 >= y_lo) && (by11 <= y_lo + 11'(ALIEN_H - 1));
    end
  end

  // A pending hit masks detection so the retiring bullet is never counted twice.
  assign cand = in_box & alien_alive & {N{bullet_on_screen & ~hit}};

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    kill      = '0;
    det_found = 1'b0;
    det_pts   = '0;
    // Later matches overwrite earlier ones: highest row wins, then lowest column.
    for (int r = 0; r < ROWS; r++) begin
      for (int c = COLS - 1; c >= 0; c--) begin
        if (cand[r*COLS+c]) begin
          det_found        = 1'b1;
          kill             = '0;
          kill[r*COLS+c]   = 1'b1;
          det_pts          = 16'(10 * (ROWS - r));
        end
      end
    end
  end

`ifdef ALIEN_SPEEDUP_EN
  localparam int CNT_W = $clog2(N + 1);
  logic [CNT_W-1:0] live_cnt;

  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < N; i++) live_cnt = live_cnt + CNT_W'(alien_alive[i]);
  end

  always_comb begin
    period = PERIOD_FULL;
    if (live_cnt == CNT_W'(1))                     period = PER_W'(1);
    else if (live_cnt <= CNT_W'(8))                period = PERIOD_FULL >> 2;
    else if ({live_cnt, 1'b0} <= (CNT_W + 1)'(N))  period = PERIOD_FULL >> 1;
  end
`else
  assign period = PERIOD_FULL;
`endif

  // Using >= lets a shortened period fire immediately when the divider is already past it.
  assign wrap = (period <= PER_W'(1)) || ({1'b0, divider} >= period - PER_W'(1));

  assign nx_r     = gx11 + 11'(STEP_X);
  assign nx_l     = gx11 - 11'(STEP_X);
  assign right_ok = (nx_r + 11'(SPAN)) <= 11'(X_MAX);
  assign left_ok  = gx11 >= 11'(X_MIN + STEP_X);

  assign score_sum = {1'b0, score} + {1'b0, det_pts};

  always_comb begin
    hit_n   = det_found;
    wave_n  = 1'b0;
    alive_n = alien_alive & ~kill;
    score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    gx_n    = grid_X;
    gy_n    = grid_Y;
    dir_n   = dir;
    div_n   = wrap ? '0 : divider + DIV_W'(1);

    if (wrap) begin
      if (dir == DIR_RIGHT && right_ok)     gx_n = 10'(nx_r);
      else if (dir == DIR_LEFT && left_ok)  gx_n = 10'(nx_l);
      else begin
        gy_n  = grid_Y + 10'(STEP_Y);
        dir_n = (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
      end
    end

    if (alien_alive == '0) begin
      wave_n  = 1'b1;
      alive_n = '1;
      gx_n    = 10'(START_X);
      gy_n    = 10'(START_Y);
      dir_n   = DIR_RIGHT;
      div_n   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      hit         <= 1'b0;
      wave_clear  <= 1'b0;
      score       <= '0;
      alien_alive <= '1;
      grid_X      <= 10'(START_X);
      grid_Y      <= 10'(START_Y);
      dir         <= DIR_RIGHT;
      divider     <= '0;
    end else begin
      hit         <= hit_n;
      wave_clear  <= wave_n;
      score       <= score_n;
      alien_alive <= alive_n;
      grid_X      <= gx_n;
      grid_Y      <= gy_n;
      dir         <= dir_n;
      divider     <= div_n;
    end
  end

endmodule
